// File: rtl/seg_display_driver_if.sv
// Input bundle for the 7-segment display driver: captured digit bus plus
// blink and blanking controls.
interface seg_display_driver_if;
    logic [29:0] seg_data;
    logic        load;
    logic [5:0]  blink_en;
    logic        blink_restart;
    logic        blank;

    modport master (
        output seg_data,
        output load,
        output blink_en,
        output blink_restart,
        output blank
    );

    modport slave (
        input seg_data,
        input load,
        input blink_en,
        input blink_restart,
        input blank
    );
endinterface

// File: rtl/seg_display_driver.sv
// Registered six-digit 7-segment driver: captures {ext, hex} fields, decodes them
// through a standard or extended glyph set, and applies per-digit blink and blanking.
module seg_display_driver #(
    parameter int unsigned BLINK_DIV = 25000000,
    parameter int unsigned CNT_W     = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_display_driver_if.slave   bus,
    output logic [6:0]            HEX0,
    output logic [6:0]            HEX1,
    output logic [6:0]            HEX2,
    output logic [6:0]            HEX3,
    output logic [6:0]            HEX4,
    output logic [6:0]            HEX5
);

    localparam logic [CNT_W-1:0] CntLast  = CNT_W'(BLINK_DIV - 1);
    localparam logic [29:0]      CapReset = {6{5'b10000}};
    localparam logic [6:0]       SegOff   = 7'h7F;

    logic [29:0]      cap_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [6:0]       hex_q [6];
    logic [6:0]       hex_d [6];

    // Segment code for one {ext, hex} field, active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [4:0] f);
        logic [6:0] code;
        unique case (f)
            5'h00: code = 7'h40;
            5'h01: code = 7'h79;
            5'h02: code = 7'h24;
            5'h03: code = 7'h30;
            5'h04: code = 7'h19;
            5'h05: code = 7'h12;
            5'h06: code = 7'h02;
            5'h07: code = 7'h78;
            5'h08: code = 7'h00;
            5'h09: code = 7'h10;
            5'h0A: code = 7'h08;
            5'h0B: code = 7'h03;
            5'h0C: code = 7'h46;
            5'h0D: code = 7'h21;
            5'h0E: code = 7'h06;
            5'h0F: code = 7'h0E;
            5'h10: code = 7'h7F;
            5'h11: code = 7'h3F;
            5'h12: code = 7'h0C;
            5'h13: code = 7'h47;
            5'h14: code = 7'h09;
            5'h15: code = 7'h2B;
            5'h16: code = 7'h23;
            5'h17: code = 7'h2F;
            5'h18: code = 7'h41;
            5'h19: code = 7'h63;
            5'h1A: code = 7'h07;
            5'h1B: code = 7'h11;
            5'h1C: code = 7'h61;
            5'h1D: code = 7'h77;
            5'h1E: code = 7'h7E;
            5'h1F: code = 7'h37;
        endcase
        return code;
    endfunction

    // Restart wins over a wrap in the same cycle.
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
        if (cnt_q == CntLast) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
        if (bus.blink_restart) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end
    end

    always_comb begin
        for (int n = 0; n < 6; n++) begin
            hex_d[n] = decode(cap_q[5*n +: 5]);
            if (bus.blank) begin
                hex_d[n] = SegOff;
            end else if (bus.blink_en[n] && phase_q) begin
                hex_d[n] = SegOff;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q   <= CapReset;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            for (int n = 0; n < 6; n++) begin
                hex_q[n] <= SegOff;
            end
        end else begin
            if (bus.load) begin
                cap_q <= bus.seg_data;
            end
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            for (int n = 0; n < 6; n++) begin
                hex_q[n] <= hex_d[n];
            end
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver with a 4-cycle blink half-period.
module tb_seg_display_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [6:0] hex_obs [6];
    int         checks   = 0;
    int         failures = 0;

    seg_display_driver_if bus ();

    seg_display_driver #(
        .BLINK_DIV(4),
        .CNT_W    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .HEX0(hex0),
        .HEX1(hex1),
        .HEX2(hex2),
        .HEX3(hex3),
        .HEX4(hex4),
        .HEX5(hex5)
    );

    always #5 clk = ~clk;

    assign hex_obs[0] = hex0;
    assign hex_obs[1] = hex1;
    assign hex_obs[2] = hex2;
    assign hex_obs[3] = hex3;
    assign hex_obs[4] = hex4;
    assign hex_obs[5] = hex5;

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [29:0] pack6(input logic [4:0] d5, input logic [4:0] d4,
                                          input logic [4:0] d3, input logic [4:0] d2,
                                          input logic [4:0] d1, input logic [4:0] d0);
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic test_reset();
        rst               = 1'b1;
        bus.seg_data      = 30'h0;
        bus.load          = 1'b1;
        bus.blink_en      = 6'b0;
        bus.blink_restart = 1'b0;
        bus.blank         = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) begin
                rst      = 1'b0;
                bus.load = 1'b0;
            end
            tick();
            for (int n = 0; n < 6; n++) begin
                checks++;
                if (hex_obs[n] !== 7'h7F) begin
                    failures++;
                    $display("FAIL reset c%0d HEX%0d got %h exp 7f", c, n, hex_obs[n]);
                end
            end
        end
    endtask

    task automatic test_std_decode();
        logic [29:0] vec [3];
        logic [6:0]  exp [3][6];
        vec[0] = pack6(5'h05, 5'h04, 5'h03, 5'h02, 5'h01, 5'h00);
        vec[1] = pack6(5'h0B, 5'h0A, 5'h09, 5'h08, 5'h07, 5'h06);
        vec[2] = pack6(5'h0F, 5'h0E, 5'h0D, 5'h0C, 5'h0B, 5'h0A);
        exp[0] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
        exp[1] = '{7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03};
        exp[2] = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        for (int v = 0; v < 3; v++) begin
            bus.seg_data = vec[v];
            bus.load     = 1'b1;
            tick();
            bus.load = 1'b0;
            if (v == 0) begin
                // Capture edge alone must not reach the outputs yet.
                checks++;
                if (hex0 !== 7'h7F) begin
                    failures++;
                    $display("FAIL std_latency HEX0 got %h exp 7f", hex0);
                end
            end
            tick();
            for (int n = 0; n < 6; n++) begin
                checks++;
                if (hex_obs[n] !== exp[v][n]) begin
                    failures++;
                    $display("FAIL std_decode v%0d HEX%0d got %h exp %h", v, n, hex_obs[n],
                             exp[v][n]);
                end
            end
        end
    endtask

    task automatic test_ext_decode();
        logic [29:0] vec [3];
        logic [6:0]  exp [3][6];
        vec[0] = pack6(5'h12, 5'h13, 5'h14, 5'h17, 5'h11, 5'h10);
        vec[1] = pack6(5'h15, 5'h16, 5'h18, 5'h19, 5'h1A, 5'h1B);
        vec[2] = pack6(5'h1C, 5'h1D, 5'h1E, 5'h1F, 5'h10, 5'h11);
        exp[0] = '{7'h7F, 7'h3F, 7'h2F, 7'h09, 7'h47, 7'h0C};
        exp[1] = '{7'h11, 7'h07, 7'h63, 7'h41, 7'h23, 7'h2B};
        exp[2] = '{7'h3F, 7'h7F, 7'h37, 7'h7E, 7'h77, 7'h61};
        for (int v = 0; v < 3; v++) begin
            bus.seg_data = vec[v];
            bus.load     = 1'b1;
            tick();
            bus.load = 1'b0;
            tick();
            for (int n = 0; n < 6; n++) begin
                checks++;
                if (hex_obs[n] !== exp[v][n]) begin
                    failures++;
                    $display("FAIL ext_decode v%0d HEX%0d got %h exp %h", v, n, hex_obs[n],
                             exp[v][n]);
                end
            end
        end
    endtask

    // Restart at edge 0 aligns the phase; a second restart at edge 20 lands on a wrap.
    task automatic test_blink();
        logic [6:0] steady [6];
        logic [6:0] exp0;
        steady = '{7'h00, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
        bus.seg_data      = pack6(5'h05, 5'h04, 5'h03, 5'h02, 5'h01, 5'h08);
        bus.load          = 1'b1;
        bus.blink_en      = 6'b000001;
        bus.blink_restart = 1'b1;
        tick();
        bus.load          = 1'b0;
        bus.blink_restart = 1'b0;
        for (int i = 1; i <= 28; i++) begin
            if (i == 20) bus.blink_restart = 1'b1;
            tick();
            bus.blink_restart = 1'b0;
            if (i <= 16) exp0 = (((i - 1) / 4) % 2 == 1) ? 7'h7F : 7'h00;
            else         exp0 = (i >= 25) ? 7'h7F : 7'h00;
            checks++;
            if (hex0 !== exp0) begin
                failures++;
                $display("FAIL blink e%0d HEX0 got %h exp %h", i, hex0, exp0);
            end
            for (int n = 1; n < 6; n++) begin
                checks++;
                if (hex_obs[n] !== steady[n]) begin
                    failures++;
                    $display("FAIL blink_steady e%0d HEX%0d got %h exp %h", i, n,
                             hex_obs[n], steady[n]);
                end
            end
        end
        bus.blink_en = 6'b0;
    endtask

    task automatic test_blank_hold();
        logic [6:0] exp [6];
        exp = '{7'h3F, 7'h47, 7'h40, 7'h79, 7'h24, 7'h0C};
        bus.seg_data = pack6(5'h12, 5'h02, 5'h01, 5'h00, 5'h13, 5'h11);
        bus.load     = 1'b1;
        bus.blank    = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            bus.load = 1'b0;
            for (int n = 0; n < 6; n++) begin
                checks++;
                if (hex_obs[n] !== 7'h7F) begin
                    failures++;
                    $display("FAIL blank c%0d HEX%0d got %h exp 7f", c, n, hex_obs[n]);
                end
            end
        end
        bus.blank = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            bus.seg_data = 30'h0ABC_DEF ^ (30'(c) << 7);
            for (int n = 0; n < 6; n++) begin
                checks++;
                if (hex_obs[n] !== exp[n]) begin
                    failures++;
                    $display("FAIL hold c%0d HEX%0d got %h exp %h", c, n, hex_obs[n], exp[n]);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        bus.seg_data = pack6(5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
        bus.load     = 1'b1;
        rst          = 1'b1;
        tick();
        rst      = 1'b0;
        bus.load = 1'b0;
        for (int c = 0; c < 2; c++) begin
            for (int n = 0; n < 6; n++) begin
                checks++;
                if (hex_obs[n] !== 7'h7F) begin
                    failures++;
                    $display("FAIL reset_midop c%0d HEX%0d got %h exp 7f", c, n, hex_obs[n]);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_std_decode();
        test_ext_decode();
        test_blink();
        test_blank_hold();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
